lm_sm_sequencer: RTL and testbench

- Multi-cycle sequencer for the LM (opcode 0110) and SM (opcode 0111) instructions.
- The decode stage does not expand the register list, so this block does it:
  - captures the instruction, its 8-bit register list and the base address (RA contents);
  - issues one register-transfer micro-op per cycle to the register-read/memory stages;
  - holds fetch/decode stalled until the list is exhausted.
- Sits beside the decode stage, between pipeline register 1 and the register-read stage.

---
 rtl/lm_sm_sequencer.sv | 105 ++++++++++
 tb/tb_lm_sm_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM register-list expander issuing one transfer micro-op per cycle
module lm_sm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [15:0]       ir,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              stall_in,
   input  logic              flush,
   output logic              busy,
   output logic              stall_fetch,
   output logic              uop_valid,
   output logic              uop_is_store,
   output logic [2:0]        uop_reg,
   output logic [ADDR_W-1:0] uop_addr,
   output logic [3:0]        remaining,
   output logic              done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state, state_nxt;
   logic [NREG-1:0]   list_q;
   logic [ADDR_W-1:0] addr_q;
   logic              is_store_q;

   logic              accept;
   logic              consume;
   logic              last_bit;
   logic [NREG-1:0]   low_mask;
   logic [2:0]        low_idx;
   logic [3:0]        pop_cnt;

   assign accept   = (state == ST_IDLE) && start && (ir[15:13] == 3'b011) && !flush;
   assign consume  = (state == ST_RUN) && !stall_in;
   // Isolate the lowest set bit; the sequence ends when nothing else is left.
   assign low_mask = list_q & (~list_q + NREG'(1));
   assign last_bit = (list_q & ~low_mask) == '0;

   always_comb begin
      low_idx = '0;
      pop_cnt = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (list_q[i]) low_idx = 3'(i);
         pop_cnt = pop_cnt + {3'b000, list_q[i]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      busy         = (state != ST_IDLE);
      stall_fetch  = (state != ST_IDLE) || accept;
      uop_valid    = 1'b0;
      uop_is_store = 1'b0;
      uop_reg      = '0;
      uop_addr     = '0;
      remaining    = '0;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = (ir[NREG-1:0] != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            uop_valid    = 1'b1;
            uop_is_store = is_store_q;
            uop_reg      = low_idx;
            uop_addr     = addr_q;
            remaining    = pop_cnt;
            if (consume && last_bit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         list_q     <= '0;
         addr_q     <= '0;
         is_store_q <= 1'b0;
      end else if (flush) begin
         list_q <= '0;
      end else if (accept) begin
         list_q     <= ir[NREG-1:0];
         addr_q     <= base_addr;
         is_store_q <= ir[12];
      end else if (consume) begin
         list_q <= list_q & ~low_mask;
         addr_q <= addr_q + ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - randomized self-checking bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] ir;
   logic [15:0] base_addr;
   logic        stall_in;
   logic        flush;
   logic        busy;
   logic        stall_fetch;
   logic        uop_valid;
   logic        uop_is_store;
   logic [2:0]  uop_reg;
   logic [15:0] uop_addr;
   logic [3:0]  remaining;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0]  r;
      logic [15:0] a;
   } xfer_t;

   // Reference: pending transfers as a queue plus a flag for the outstanding done pulse.
   xfer_t q[$];
   bit    done_pend = 1'b0;
   bit    m_store   = 1'b0;

   lm_sm_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .ir           (ir),
      .base_addr    (base_addr),
      .stall_in     (stall_in),
      .flush        (flush),
      .busy         (busy),
      .stall_fetch  (stall_fetch),
      .uop_valid    (uop_valid),
      .uop_is_store (uop_is_store),
      .uop_reg      (uop_reg),
      .uop_addr     (uop_addr),
      .remaining    (remaining),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic [15:0] i, input logic [15:0] b,
                       input logic st, input logic fl);
      bit exp_busy, exp_acc;
      int n;
      @(negedge clk);
      start = s; ir = i; base_addr = b; stall_in = st; flush = fl;
      #1;
      exp_busy = (q.size() != 0) || done_pend;
      exp_acc  = !exp_busy && s && (i[15:13] == 3'b011) && !fl;
      check("busy",        32'(busy),        32'(exp_busy));
      check("stall_fetch", 32'(stall_fetch), 32'(exp_busy || exp_acc));
      check("uop_valid",   32'(uop_valid),   32'(q.size() != 0));
      check("done",        32'(done),        32'(q.size() == 0 && done_pend));
      check("remaining",   32'(remaining),   32'(q.size()));
      if (q.size() != 0) begin
         check("uop_reg",      32'(uop_reg),      32'(q[0].r));
         check("uop_addr",     32'(uop_addr),     32'(q[0].a));
         check("uop_is_store", 32'(uop_is_store), 32'(m_store));
      end
      if (fl) begin
         q.delete();
         done_pend = 1'b0;
      end else if (q.size() != 0) begin
         if (!st) void'(q.pop_front());
      end else if (done_pend) begin
         done_pend = 1'b0;
      end else if (exp_acc) begin
         m_store = i[12];
         n = 0;
         for (int k = 0; k < 8; k++) begin
            if (i[k]) begin
               q.push_back('{r: 3'(k), a: b + 16'(n)});
               n++;
            end
         end
         done_pend = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   32'(busy),         32'd0);
      check({tag, "_sf"},     32'(stall_fetch),  32'd0);
      check({tag, "_valid"},  32'(uop_valid),    32'd0);
      check({tag, "_store"},  32'(uop_is_store), 32'd0);
      check({tag, "_reg"},    32'(uop_reg),      32'd0);
      check({tag, "_addr"},   32'(uop_addr),     32'd0);
      check({tag, "_rem"},    32'(remaining),    32'd0);
      check({tag, "_done"},   32'(done),         32'd0);
   endtask

   logic [15:0] r_ir;
   logic [7:0]  r_list;
   logic [3:0]  r_op;

   initial begin
      reset_n = 1'b0; start = 1'b0; ir = '0; base_addr = '0; stall_in = 1'b0; flush = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;

      // LM list A5 from 0x0040
      step(1'b1, 16'h60A5, 16'h0040, 1'b0, 1'b0);
      idle(6);
      // SM single R7 at 0xFFFF, then two transfers wrapping to 0x0000
      step(1'b1, 16'h7080, 16'hFFFF, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 16'h70C0, 16'hFFFF, 1'b0, 1'b0);
      idle(4);
      // Empty list
      step(1'b1, 16'h6000, 16'h1234, 1'b0, 1'b0);
      idle(3);
      // Stall three cycles on the second transfer
      step(1'b1, 16'h600F, 16'h0100, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      idle(5);
      // Flush on the third transfer, then a fresh LM
      step(1'b1, 16'h60FF, 16'h0200, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      idle(1);
      step(1'b1, 16'h6012, 16'h0300, 1'b0, 1'b0);
      idle(4);
      // Non-LM/SM opcode ignored, flush with start blocks accept, start while busy ignored
      step(1'b1, 16'h00FF, 16'h0400, 1'b0, 1'b0);
      step(1'b1, 16'h60FF, 16'h0400, 1'b0, 1'b1);
      step(1'b1, 16'h6003, 16'h0500, 1'b0, 1'b0);
      step(1'b1, 16'h70F0, 16'h0600, 1'b0, 1'b0);
      step(1'b1, 16'h7001, 16'h0700, 1'b0, 1'b0);
      idle(3);
      // Asynchronous reset in the middle of a sequence
      step(1'b1, 16'h60FF, 16'h0800, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("midreset");
      q.delete();
      done_pend = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      for (int c = 0; c < 4000; c++) begin
         r_op   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : {3'b011, 1'($urandom)};
         r_list = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         r_ir   = {r_op, 4'($urandom), r_list};
         step($urandom_range(0, 99) < 40, r_ir,
              ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom),
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
      end
      idle(12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
